mem_wb_skid: RTL

//  Parametrised MEM->WB pipeline stage that replaces the bare stall-gated register.

---
 rtl/mem_wb_skid.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM->WB pipeline stage with 2-entry skid buffer, flush and forwarding lookup
module mem_wb_skid #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_SUPP = 1,
    parameter int FWD_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic              mem_wreg_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic              wb_wreg_o,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    input  logic [ADDR_W-1:0] fwd_raddr_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    logic              h_valid_q, h_valid_d;
    logic              h_wreg_q,  h_wreg_d;
    logic [ADDR_W-1:0] h_waddr_q, h_waddr_d;
    logic [DATA_W-1:0] h_wdata_q, h_wdata_d;
    logic              s_valid_q, s_valid_d;
    logic              s_wreg_q,  s_wreg_d;
    logic [ADDR_W-1:0] s_waddr_q, s_waddr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;

    logic accept;
    logic pop;
    logic in_wreg;

    // Ready comes only from the skid valid bit so no path from wb_ready_i reaches MEM.
    assign mem_ready_o = !s_valid_q;
    assign accept      = mem_valid_i & mem_ready_o & !flush_i;
    assign pop         = h_valid_q & wb_ready_i & !flush_i;
    assign in_wreg     = (ZERO_SUPP != 0) ? (mem_wreg_i & (mem_waddr_i != '0)) : mem_wreg_i;

    always_comb begin
        h_valid_d = h_valid_q;
        h_wreg_d  = h_wreg_q;
        h_waddr_d = h_waddr_q;
        h_wdata_d = h_wdata_q;
        s_valid_d = s_valid_q;
        s_wreg_d  = s_wreg_q;
        s_waddr_d = s_waddr_q;
        s_wdata_d = s_wdata_q;

        if (flush_i) begin
            h_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!h_valid_q) begin
            if (accept) begin
                h_valid_d = 1'b1;
                h_wreg_d  = in_wreg;
                h_waddr_d = mem_waddr_i;
                h_wdata_d = mem_wdata_i;
            end
        end else if (!s_valid_q) begin
            if (accept && pop) begin
                h_wreg_d  = in_wreg;
                h_waddr_d = mem_waddr_i;
                h_wdata_d = mem_wdata_i;
            end else if (accept) begin
                s_valid_d = 1'b1;
                s_wreg_d  = in_wreg;
                s_waddr_d = mem_waddr_i;
                s_wdata_d = mem_wdata_i;
            end else if (pop) begin
                h_valid_d = 1'b0;
            end
        end else if (pop) begin
            h_wreg_d  = s_wreg_q;
            h_waddr_d = s_waddr_q;
            h_wdata_d = s_wdata_q;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_valid_q <= 1'b0;
            h_wreg_q  <= 1'b0;
            h_waddr_q <= '0;
            h_wdata_q <= '0;
            s_valid_q <= 1'b0;
            s_wreg_q  <= 1'b0;
            s_waddr_q <= '0;
            s_wdata_q <= '0;
        end else begin
            h_valid_q <= h_valid_d;
            h_wreg_q  <= h_wreg_d;
            h_waddr_q <= h_waddr_d;
            h_wdata_q <= h_wdata_d;
            s_valid_q <= s_valid_d;
            s_wreg_q  <= s_wreg_d;
            s_waddr_q <= s_waddr_d;
            s_wdata_q <= s_wdata_d;
        end
    end

    assign wb_valid_o = h_valid_q;
    assign wb_wreg_o  = h_valid_q & h_wreg_q;
    assign wb_waddr_o = h_waddr_q;
    assign wb_wdata_o = h_wdata_q;

    generate
        if (FWD_EN != 0) begin : g_fwd
            logic h_match;
            logic s_match;
            assign h_match = h_valid_q & h_wreg_q & (h_waddr_q == fwd_raddr_i) & (fwd_raddr_i != '0);
            assign s_match = s_valid_q & s_wreg_q & (s_waddr_q == fwd_raddr_i) & (fwd_raddr_i != '0);

            // The skid entry is younger, so it shadows the head on a double match.
            always_comb begin
                fwd_hit_o  = s_match | h_match;
                fwd_data_o = '0;
                if (s_match) begin
                    fwd_data_o = s_wdata_q;
                end else if (h_match) begin
                    fwd_data_o = h_wdata_q;
                end
            end
        end else begin : g_no_fwd
            assign fwd_hit_o  = 1'b0;
            assign fwd_data_o = '0;
        end
    endgenerate

endmodule
